// File: rtl/snake_body_tracker.sv
// Snake segment list with movement, growth, wall/self collision flags and a
// registered per-pixel cell classifier. Optional macro SNAKE_WRAP_EN: toroidal playfield.
module snake_body_tracker #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned START_X  = 20,
  parameter int unsigned START_Y  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_tick,
  input  logic [1:0] dir,
  input  logic       grow,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic [1:0] snake,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [6:0] length,
  output logic       wall_hit,
  output logic       self_hit
);
  localparam int unsigned XW   = 6;
  localparam int unsigned YW   = 5;
  localparam int unsigned LW   = 7;
  localparam int unsigned COLS = 40;
  localparam int unsigned ROWS = 30;

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
  localparam logic [LW-1:0] L_MAX = LW'(MAX_LEN);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_HEAD = 2'b01;
  localparam logic [1:0] CLS_BODY = 2'b10;
  localparam logic [1:0] CLS_WALL = 2'b11;

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic [LW-1:0] len_q, len_d;
  logic [1:0]    cur_dir_q, cur_dir_d;
  logic          grow_pend_q, grow_pend_d;
  logic          wall_q, wall_d;
  logic          self_q, self_d;
  logic [1:0]    snake_q, snake_d;

  logic [1:0]    new_dir;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          grow_eff;
  logic          wall_next;
  logic          self_next;

  // Direction filter and next head cell
  always_comb begin
    new_dir = dir;
    if ((dir[1] == cur_dir_q[1]) && (dir[0] != cur_dir_q[0])) new_dir = cur_dir_q;
    nx = seg_x_q[0];
    ny = seg_y_q[0];
    unique case (new_dir)
      DIR_UP:    ny = (WRAP && seg_y_q[0] == '0)   ? Y_MAX : seg_y_q[0] - YW'(1);
      DIR_DOWN:  ny = (WRAP && seg_y_q[0] == Y_MAX) ? '0    : seg_y_q[0] + YW'(1);
      DIR_LEFT:  nx = (WRAP && seg_x_q[0] == '0)   ? X_MAX : seg_x_q[0] - XW'(1);
      DIR_RIGHT: nx = (WRAP && seg_x_q[0] == X_MAX) ? '0    : seg_x_q[0] + XW'(1);
      default:   nx = seg_x_q[0];
    endcase
  end

  // Collision detection; the tail vacates its cell unless the snake grows
  always_comb begin
    grow_eff  = grow_pend_q | grow;
    wall_next = !WRAP && ((nx == '0) || (nx >= X_MAX) || (ny == '0) || (ny >= Y_MAX));
    self_next = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if ((LW'(i) < len_q) && !(!grow_eff && (LW'(i) == len_q - LW'(1))) &&
          (seg_x_q[i] == nx) && (seg_y_q[i] == ny))
        self_next = 1'b1;
    end
  end

  // Segment, length and flag update
  always_comb begin
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    len_d       = len_q;
    cur_dir_d   = cur_dir_q;
    grow_pend_d = grow_pend_q;
    wall_d      = wall_q;
    self_d      = self_q;
    if (!wall_q && !self_q) begin
      grow_pend_d = grow_eff;
      if (move_tick) begin
        if (wall_next) begin
          wall_d = 1'b1;
        end else if (self_next) begin
          self_d = 1'b1;
        end else begin
          for (int unsigned i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0]  = nx;
          seg_y_d[0]  = ny;
          cur_dir_d   = new_dir;
          grow_pend_d = 1'b0;
          if (grow_eff && (len_q < L_MAX)) len_d = len_q + LW'(1);
        end
      end
    end
  end

  // Pixel classifier against the pre-update segment list
  always_comb begin
    logic [XW-1:0] qx;
    logic [YW-1:0] qy;
    logic          body;
    qx      = x_pos[9:4];
    qy      = y_pos[8:4];
    body    = 1'b0;
    snake_d = CLS_NONE;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if ((LW'(i) < len_q) && (seg_x_q[i] == qx) && (seg_y_q[i] == qy)) body = 1'b1;
    end
    if ((x_pos >= 10'd640) || (y_pos >= 10'd480)) snake_d = CLS_NONE;
    else if (!WRAP && ((qx == '0) || (qx == X_MAX) || (qy == '0) || (qy == Y_MAX)))
      snake_d = CLS_WALL;
    else if ((seg_x_q[0] == qx) && (seg_y_q[0] == qy)) snake_d = CLS_HEAD;
    else if (body) snake_d = CLS_BODY;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? XW'(START_X - i) : '0;
        seg_y_q[i] <= YW'(START_Y);
      end
      len_q       <= LW'(INIT_LEN);
      cur_dir_q   <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
      wall_q      <= 1'b0;
      self_q      <= 1'b0;
      snake_q     <= CLS_NONE;
    end else begin
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      len_q       <= len_d;
      cur_dir_q   <= cur_dir_d;
      grow_pend_q <= grow_pend_d;
      wall_q      <= wall_d;
      self_q      <= self_d;
      snake_q     <= snake_d;
    end
  end

  assign snake    = snake_q;
  assign head_x   = seg_x_q[0];
  assign head_y   = seg_y_q[0];
  assign length   = len_q;
  assign wall_hit = wall_q;
  assign self_hit = self_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboard bench for snake_body_tracker: queue-based snake model, directed + random stimulus.
module tb_snake_body_tracker;
  localparam int MAX_LEN = 16;
  localparam int INIT_LEN = 3;
  localparam int SX = 20;
  localparam int SY = 15;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, move_tick, grow;
  logic [1:0] dir;
  logic [9:0] x_pos, y_pos;
  logic [1:0] snake;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [6:0] length;
  logic       wall_hit, self_hit;

  snake_body_tracker #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .START_X(SX), .START_Y(SY)) dut (
    .clk(clk), .rst(rst), .start(start), .move_tick(move_tick), .dir(dir), .grow(grow),
    .x_pos(x_pos), .y_pos(y_pos), .snake(snake), .head_x(head_x), .head_y(head_y),
    .length(length), .wall_hit(wall_hit), .self_hit(self_hit));

  always #5 clk = ~clk;

  typedef struct {
    int snake; int hx; int hy; int len; int wh; int sh;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: snake as a queue of cells, head at the front
  int bx[$];
  int by[$];
  int m_dir, m_gp, m_wall, m_self, m_snake;

  function automatic int classify(int px, int py);
    int cx, cy;
    if (px >= 640 || py >= 480) return 0;
    cx = px / 16;
    cy = py / 16;
    if (!WRAP && (cx == 0 || cx == 39 || cy == 0 || cy == 29)) return 3;
    if (cx == bx[0] && cy == by[0]) return 1;
    for (int k = 1; k < bx.size(); k++) if (cx == bx[k] && cy == by[k]) return 2;
    return 0;
  endfunction

  task automatic m_init();
    bx.delete(); by.delete();
    for (int k = 0; k < INIT_LEN; k++) begin bx.push_back(SX - k); by.push_back(SY); end
    m_dir = 3; m_gp = 0; m_wall = 0; m_self = 0; m_snake = 0;
  endtask

  task automatic m_step(input bit r, input bit s, input bit t, input int d, input bit g,
                        input int px, input int py);
    int nd, nx, ny, ge;
    bit hit;
    if (r || s) begin m_init(); return; end
    m_snake = classify(px, py);
    if (m_wall || m_self) return;
    ge = m_gp | int'(g);
    m_gp = ge;
    if (!t) return;
    // opposite pairs: up/down = 0/1, left/right = 2/3
    nd = ((d ^ m_dir) == 1) ? m_dir : d;
    nx = bx[0] + ((nd == 3) ? 1 : (nd == 2) ? -1 : 0);
    ny = by[0] + ((nd == 1) ? 1 : (nd == 0) ? -1 : 0);
    if (WRAP) begin nx = (nx + 40) % 40; ny = (ny + 30) % 30; end
    if (!WRAP && (nx <= 0 || nx >= 39 || ny <= 0 || ny >= 29)) begin m_wall = 1; return; end
    hit = 0;
    for (int k = 1; k < bx.size(); k++)
      if (!(ge == 0 && k == bx.size() - 1) && nx == bx[k] && ny == by[k]) hit = 1;
    if (hit) begin m_self = 1; return; end
    bx.push_front(nx); by.push_front(ny);
    if (!(ge != 0 && bx.size() <= MAX_LEN)) begin void'(bx.pop_back()); void'(by.pop_back()); end
    m_gp = 0;
    m_dir = nd;
  endtask

  task automatic drive(input bit r, input bit s, input bit t, input int d, input bit g,
                       input int px, input int py);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; move_tick = t; dir = 2'(d); grow = g;
    x_pos = 10'(px); y_pos = 10'(py);
    m_step(r, s, t, d, g, px, py);
    e.snake = m_snake; e.hx = bx[0]; e.hy = by[0]; e.len = bx.size();
    e.wh = m_wall; e.sh = m_self;
    sb.push_back(e);
  endtask

  task automatic idle(input int px, input int py);
    drive(0, 0, 0, 0, 0, px, py);
  endtask

  task automatic mv(input int d, input bit g, input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 1, d, g, 320, 240);
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  // Monitor: every cycle the DUT presents outputs for the previous cycle's inputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("snake", int'(snake), e.snake);
        chk("head_x", int'(head_x), e.hx);
        chk("head_y", int'(head_y), e.hy);
        chk("length", int'(length), e.len);
        chk("wall_hit", int'(wall_hit), e.wh);
        chk("self_hit", int'(self_hit), e.sh);
      end
    end
  end

  initial begin
    int rd, px, py;
    bit t, g, s, r;
    rst = 1'b1; start = 1'b0; move_tick = 1'b0; grow = 1'b0; dir = 2'b11;
    x_pos = '0; y_pos = '0;
    m_init();
    drive(1, 0, 0, 3, 0, 0, 0);
    drive(1, 0, 0, 3, 0, 0, 0);
    // pixel queries: head, body, wall, off-screen
    idle(320, 240); idle(304, 240); idle(5, 100); idle(700, 100); idle(100, 500);
    idle(0, 0);
    mv(3, 0, 3);
    idle(288, 240); idle(368, 240); idle(352, 240);
    drive(0, 0, 0, 3, 1, 0, 0);
    mv(3, 0, 1);
    mv(3, 1, 1);
    // growth saturation along a non-crossing path
    drive(0, 1, 0, 3, 0, 0, 0);
    mv(3, 1, 15); mv(1, 1, 10); mv(2, 1, 20);
    // reverse is ignored, then run into the right wall
    drive(0, 1, 0, 3, 0, 0, 0);
    mv(2, 0, 1);
    mv(3, 0, 20);
    mv(0, 1, 3);
    idle(608, 240);
    drive(0, 1, 0, 3, 0, 0, 0);
    // self collision on a tight loop with length 5
    drive(0, 0, 0, 3, 1, 0, 0); mv(3, 0, 1);
    drive(0, 0, 0, 3, 1, 0, 0); mv(3, 0, 1);
    mv(3, 0, 1); mv(1, 0, 1); mv(2, 0, 1); mv(0, 0, 1); mv(3, 0, 2);
    drive(0, 0, 0, 3, 0, 0, 0);
    drive(1, 1, 0, 3, 0, 0, 0);
    // randomized play
    rd = 3;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 7) == 0) rd = int'($urandom_range(0, 3));
      t = ($urandom_range(0, 2) == 0);
      g = ($urandom_range(0, 4) == 0);
      s = ((m_wall || m_self) && $urandom_range(0, 5) == 0) || ($urandom_range(0, 400) == 0);
      r = ($urandom_range(0, 700) == 0);
      if ($urandom_range(0, 1) == 0) begin
        px = (bx[0] + int'($urandom_range(0, 4)) - 2) * 16 + int'($urandom_range(0, 15));
        py = (by[0] + int'($urandom_range(0, 4)) - 2) * 16 + int'($urandom_range(0, 15));
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
      end
      drive(r, s, t, rd, g, px, py);
    end
    idle(0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
